// File: rtl/data_reg_reader_if.sv
// Output link of the data register reader: one tagged word per accepted
// valid/ready transfer.
//   master : drives outData, outAddr, outValid (and outParity); samples outReady
//   slave  : the consumer side of the same link
// Optional: DATA_REG_READER_PARITY_EN adds outParity (even parity of outData).
interface data_reg_reader_if #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 2
);
   logic [WIDTH-1:0]  outData;
   logic [ADDR_W-1:0] outAddr;
   logic              outValid;
   logic              outReady;
`ifdef DATA_REG_READER_PARITY_EN
   logic              outParity;
`endif

   modport master (
      input  outReady,
      output outData,
      output outAddr,
      output outValid
`ifdef DATA_REG_READER_PARITY_EN
      , output outParity
`endif
   );

   modport slave (
      output outReady,
      input  outData,
      input  outAddr,
      input  outValid
`ifdef DATA_REG_READER_PARITY_EN
      , input outParity
`endif
   );
endinterface

// File: rtl/data_reg_reader.sv
// Drain end of the data register bank. A start in IDLE snapshots all
// NUM_WORDS bank words in one cycle, then the words are streamed out one per
// accepted transfer on the valid/ready link, each tagged with its address.
// A one-cycle done pulse follows the last accepted word; abort drops the
// stream without done.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   dataAll    : bank words, word k at [k*WIDTH +: WIDTH]
//   start      : begin a read-out (only looked at in IDLE)
//   abort      : cancel a read-out in progress (wins over start/transfer)
//   busy       : high while streaming
//   done       : one-cycle pulse after the last word is accepted
//   link       : master side of data_reg_reader_if (outData/outAddr/outValid/outReady)
// Optional feature macro: DATA_REG_READER_PARITY_EN adds link.outParity, the
// even parity of the word on outData, registered with it.
// NUM_WORDS must equal 2**ADDR_W.
module data_reg_reader #(
   parameter int WIDTH     = 32,
   parameter int NUM_WORDS = 4,
   parameter int ADDR_W    = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH*NUM_WORDS-1:0] dataAll,
   input  logic                       start,
   input  logic                       abort,
   output logic                       busy,
   output logic                       done,
   data_reg_reader_if.master          link
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

   state_t                           state;
   logic [NUM_WORDS-1:0][WIDTH-1:0]  snapshot;
   logic [ADDR_W-1:0]                index;
   logic [ADDR_W-1:0]                index_nx;
   logic [WIDTH-1:0]                 word_nx;
   logic [WIDTH-1:0]                 word_first;

   assign index_nx   = index + 1'b1;
   assign word_nx    = snapshot[index_nx];
   // The first word goes straight from the bus so it is valid one cycle
   // after start, while the snapshot register is being loaded.
   assign word_first = dataAll[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         snapshot      <= '0;
         index         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         link.outData  <= '0;
         link.outAddr  <= '0;
         link.outValid <= 1'b0;
`ifdef DATA_REG_READER_PARITY_EN
         link.outParity <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && !abort) begin
                  snapshot      <= dataAll;
                  index         <= '0;
                  state         <= SEND;
                  busy          <= 1'b1;
                  link.outValid <= 1'b1;
                  link.outData  <= word_first;
                  link.outAddr  <= '0;
`ifdef DATA_REG_READER_PARITY_EN
                  link.outParity <= ^word_first;
`endif
               end
            end
            SEND: begin
               // outValid is always high in SEND, so outReady alone marks a
               // transfer; abort overrides it and the word is not consumed.
               if (abort) begin
                  state         <= IDLE;
                  busy          <= 1'b0;
                  link.outValid <= 1'b0;
               end else if (link.outReady) begin
                  if (index == LAST) begin
                     state         <= DONE;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                     link.outValid <= 1'b0;
                  end else begin
                     index         <= index_nx;
                     link.outData  <= word_nx;
                     link.outAddr  <= index_nx;
`ifdef DATA_REG_READER_PARITY_EN
                     link.outParity <= ^word_nx;
`endif
                  end
               end
            end
            DONE: begin
               // start is deliberately ignored here; it is not queued.
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state         <= IDLE;
               busy          <= 1'b0;
               done          <= 1'b0;
               link.outValid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_reg_reader.sv
module tb_data_reg_reader;
   localparam int W  = 32;
   localparam int N  = 4;
   localparam int AW = 2;

   typedef logic [AW+W-1:0] ent_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [W*N-1:0]   dataAll;
   logic             start, abort, rdy;
   logic             busy, done;

   data_reg_reader_if #(.WIDTH(W), .ADDR_W(AW)) bus ();
   assign bus.outReady = rdy;

   data_reg_reader #(.WIDTH(W), .NUM_WORDS(N), .ADDR_W(AW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .dataAll (dataAll),
      .start   (start),
      .abort   (abort),
      .busy    (busy),
      .done    (done),
      .link    (bus.master)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // Reference model: the pending stream is a queue of {addr,data}; the
   // head is what must be on the link, an empty queue means nothing valid.
   ent_t mq[$];
   bit   m_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_done = 1'b0;
      end else if (mq.size() > 0) begin
         m_done = 1'b0;
         if (abort) mq.delete();
         else if (rdy) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_done = 1'b1;
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (start && !abort) begin
         for (int k = 0; k < N; k++) mq.push_back({AW'(k), dataAll[k*W +: W]});
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("outValid", bus.outValid, mq.size() > 0);
         chk("busy", busy, mq.size() > 0);
         chk("done", done, m_done);
         if (mq.size() > 0) begin
            chk("outData", bus.outData, mq[0][W-1:0]);
            chk("outAddr", bus.outAddr, mq[0][AW+W-1:W]);
`ifdef DATA_REG_READER_PARITY_EN
            chk("outParity", bus.outParity, ^mq[0][W-1:0]);
`endif
         end
      end
   end

   // Accepted-transfer log and done counter for the directed checks
   ent_t obs[$];
   int   ndone;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.outValid && rdy && !abort) obs.push_back({bus.outAddr, bus.outData});
         if (done) ndone++;
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      obs.delete();
      ndone = 0;
   endtask

   // Expect words 1..n with addresses 0..n-1
   task automatic check_stream(input string nm, input int n, input int exp_done);
      ent_t e;
      chk({nm, "_len"}, obs.size(), n);
      for (int k = 0; k < n && k < obs.size(); k++) begin
         e = {AW'(k), W'(k + 1)};
         chk({nm, "_word"}, obs[k], e);
      end
      chk({nm, "_ndone"}, ndone, exp_done);
   endtask

   localparam logic [W*N-1:0] D1234 = {32'h4, 32'h3, 32'h2, 32'h1};

   initial begin
      rst_n = 1'b0; start = 1'b1; abort = 1'b0; rdy = 1'b1; dataAll = D1234;
      ndone = 0;

      // 1: reset with start held
      step(2);
      chk("rst_valid", bus.outValid, 1'b0);
      chk("rst_data", bus.outData, 32'h0);
      chk("rst_addr", bus.outAddr, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      start = 1'b0;
      rst_n = 1'b1;
      step(2);
      chk("idle_valid", bus.outValid, 1'b0);
      chk("idle_busy", busy, 1'b0);

      // 2: full-rate stream
      clear_log();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("lat1_valid", bus.outValid, 1'b1);
      chk("lat1_data", bus.outData, 32'h1);
      step(6);
      check_stream("t2", 4, 1);

      // 3: stalls, ready pattern 1,0,0,1,0,0,...
      clear_log();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         rdy = (i % 3 == 0);
         step();
      end
      rdy = 1'b1;
      step(3);
      check_stream("t3", 4, 1);

      // 4: data change mid-stream, start while busy and during DONE
      clear_log();
      start = 1'b1;
      step();
      start = 1'b0; dataAll = {N{32'hFFFF_FFFF}};
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step(2);
      chk("t4_done_cycle", done, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      step(4);
      check_stream("t4", 4, 1);
      chk("t4_no_restart", bus.outValid, 1'b0);

      // 5: abort at addr 2, then replay
      dataAll = D1234;
      clear_log();
      start = 1'b1;
      step();
      start = 1'b0;
      step(2);
      chk("t5_addr_at_abort", bus.outAddr, 2'd2);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t5_valid_after", bus.outValid, 1'b0);
      step(3);
      check_stream("t5a", 2, 0);
      clear_log();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t5_replay_addr", bus.outAddr, 2'd0);
      step(6);
      check_stream("t5b", 4, 1);

      // abort+start together in IDLE: stay idle
      clear_log();
      start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      chk("abort_start_idle", bus.outValid, 1'b0);
      step(2);
      check_stream("t5c", 0, 0);

      // reset mid-stream: snapshot dropped, no done
      clear_log();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus.outValid, 1'b0);
      chk("mid_rst_data", bus.outData, 32'h0);
      chk("mid_rst_busy", busy, 1'b0);
      step();
      rst_n = 1'b1;
      step(6);
      chk("mid_rst_ndone", ndone, 0);
      chk("mid_rst_idle", bus.outValid, 1'b0);

`ifdef DATA_REG_READER_PARITY_EN
      // 6: parity
      dataAll = {32'h0, 32'h0, 32'h3, 32'h7};
      start = 1'b1;
      step();
      start = 1'b0;
      chk("par_word7", bus.outParity, 1'b1);
      step();
      chk("par_word3", bus.outParity, 1'b0);
      step(5);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
